// File: rtl/dmem_sram_bridge.sv
// dmem_sram_bridge
// Connects the MIPS memory stage to an SRAM-like data bus that uses a split
// handshake: addr_ok accepts the request and data_ok completes it. Only one
// transaction is in flight at a time, and the core stays stalled until that
// transaction completes. Store data is replicated across the byte lanes. When
// ADDR_MAP_EN is set, kseg0/kseg1 addresses are folded onto physical space.
module dmem_sram_bridge #(
    parameter logic ADDR_MAP_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memenM,
    input  logic        memwriteM,
    input  logic [1:0]  memsizeM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    input  logic        flushM,
    output logic [31:0] readdataM,
    output logic        stallM,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Store data is right-aligned. Copy it into every lane so that the slave
    // finds it in whichever lane the address selects.
    function automatic logic [31:0] lane_replicate(input logic [1:0] size,
                                                    input logic [31:0] wd);
        logic [31:0] res;
        case (size)
            2'b00:   res = {4{wd[7:0]}};
            2'b01:   res = {2{wd[15:0]}};
            default: res = wd;
        endcase
        return res;
    endfunction

    // kseg0 and kseg1 (0x8000_0000-0xBFFF_FFFF) are unmapped windows onto the
    // low 512 MB of physical space. Every other address passes through as is.
    function automatic logic [31:0] map_addr(input logic [31:0] va);
        logic [31:0] pa;
        if (ADDR_MAP_EN && (va[31:30] == 2'b10)) begin
            pa = {3'b000, va[28:0]};
        end else begin
            pa = va;
        end
        return pa;
    endfunction

    logic [1:0]  state_q,    state_d;
    logic        data_req_q, data_req_d;
    logic        data_wr_q,  data_wr_d;
    logic [1:0]  data_size_q, data_size_d;
    logic [31:0] data_addr_q, data_addr_d;
    logic [31:0] data_wdata_q, data_wdata_d;
    logic [31:0] readdata_q, readdata_d;
    logic        discard_q,  discard_d;

    logic        req_start_s;
    logic        discard_now_s;

    assign req_start_s   = memenM & ~flushM;
    // A flush that arrives in the same cycle as data_ok still drops the data.
    assign discard_now_s = discard_q | flushM;

    // Next-state logic: transaction sequencing, bus capture and load data capture
    always_comb begin
        state_d      = state_q;
        data_req_d   = data_req_q;
        data_wr_d    = data_wr_q;
        data_size_d  = data_size_q;
        data_addr_d  = data_addr_q;
        data_wdata_d = data_wdata_q;
        readdata_d   = readdata_q;
        discard_d    = discard_q;
        case (state_q)
            ST_IDLE: begin
                if (req_start_s) begin
                    state_d      = ST_REQ;
                    data_req_d   = 1'b1;
                    data_wr_d    = memwriteM;
                    data_size_d  = (memsizeM == 2'b11) ? 2'b10 : memsizeM;
                    data_addr_d  = map_addr(aluoutM);
                    data_wdata_d = lane_replicate(memsizeM, writedataM);
                    discard_d    = 1'b0;
                end else begin
                    data_req_d = 1'b0;
                end
            end
            ST_REQ: begin
                if (data_addr_ok) begin
                    data_req_d = 1'b0;
                    if (data_data_ok) begin
                        discard_d = 1'b0;
                        if (discard_now_s) begin
                            state_d = ST_IDLE;
                        end else begin
                            readdata_d = data_rdata;
                            state_d    = ST_DONE;
                        end
                    end else begin
                        state_d   = ST_WAIT;
                        discard_d = discard_now_s;
                    end
                end else begin
                    discard_d = discard_now_s;
                end
            end
            ST_WAIT: begin
                data_req_d = 1'b0;
                if (data_data_ok) begin
                    discard_d = 1'b0;
                    if (discard_now_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        readdata_d = data_rdata;
                        state_d    = ST_DONE;
                    end
                end else begin
                    discard_d = discard_now_s;
                end
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                data_req_d = 1'b0;
                discard_d  = 1'b0;
            end
            default: begin
                state_d    = ST_IDLE;
                data_req_d = 1'b0;
                discard_d  = 1'b0;
            end
        endcase
    end

    // Stall request: hold the core from the request cycle until the cycle in which data is delivered
    always_comb begin
        stallM = 1'b0;
        if (rst) begin
            stallM = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: stallM = req_start_s;
                ST_REQ:  stallM = 1'b1;
                ST_WAIT: stallM = 1'b1;
                ST_DONE: stallM = 1'b0;
                default: stallM = 1'b0;
            endcase
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            data_req_q   <= 1'b0;
            data_wr_q    <= 1'b0;
            data_size_q  <= 2'b00;
            data_addr_q  <= 32'h0000_0000;
            data_wdata_q <= 32'h0000_0000;
            readdata_q   <= 32'h0000_0000;
            discard_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_req_q   <= data_req_d;
            data_wr_q    <= data_wr_d;
            data_size_q  <= data_size_d;
            data_addr_q  <= data_addr_d;
            data_wdata_q <= data_wdata_d;
            readdata_q   <= readdata_d;
            discard_q    <= discard_d;
        end
    end

    assign readdataM  = readdata_q;
    assign data_req   = data_req_q;
    assign data_wr    = data_wr_q;
    assign data_size  = data_size_q;
    assign data_addr  = data_addr_q;
    assign data_wdata = data_wdata_q;

endmodule

// File: tb/tb_dmem_sram_bridge.sv
// Self-checking bench for dmem_sram_bridge. The bench drives the core side and
// also acts as a bus slave whose addr_ok and data_ok delays can be programmed.
// Each access is checked against a transaction-level model that gives the
// physical address, the lane-replicated data, the stall length and the
// expected load data.
module tb_dmem_sram_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        memenM, memwriteM, flushM;
    logic [1:0]  memsizeM;
    logic [31:0] aluoutM, writedataM;
    logic [31:0] readdataM, readdataM_nm;
    logic        stallM, stallM_nm;
    logic        data_req, data_req_nm, data_wr, data_wr_nm;
    logic [1:0]  data_size, data_size_nm;
    logic [31:0] data_addr, data_addr_nm, data_wdata, data_wdata_nm;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;

    int total = 0;
    int bad   = 0;
    logic [31:0] last_rd;

    always #5 clk = ~clk;

    dmem_sram_bridge #(.ADDR_MAP_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .memenM(memenM), .memwriteM(memwriteM),
        .memsizeM(memsizeM), .aluoutM(aluoutM), .writedataM(writedataM),
        .flushM(flushM), .readdataM(readdataM), .stallM(stallM),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata)
    );

    // Second instance with the address map disabled. It sees the same stimulus.
    dmem_sram_bridge #(.ADDR_MAP_EN(1'b0)) dut_nm (
        .clk(clk), .rst(rst), .memenM(memenM), .memwriteM(memwriteM),
        .memsizeM(memsizeM), .aluoutM(aluoutM), .writedataM(writedataM),
        .flushM(flushM), .readdataM(readdataM_nm), .stallM(stallM_nm),
        .data_req(data_req_nm), .data_wr(data_wr_nm), .data_size(data_size_nm),
        .data_addr(data_addr_nm), .data_wdata(data_wdata_nm),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One access. a = number of REQ cycles before addr_ok, d = number of cycles
    // from addr_ok to data_ok, fl = cycle index at which flushM rises (-1 means no flush).
    task automatic run_access(input logic wr, input logic [1:0] sz, input logic [31:0] va,
                              input logic [31:0] wd, input logic [31:0] rd,
                              input int a, input int d, input int fl);
        int req_cnt = 0, dcnt = 0, req_cycles = 0, stall_cycles = 0;
        bit accepted = 0, bus_done = 0, finished = 0, disc, ok_now;
        logic [31:0] exp_pa, exp_wd;
        logic [1:0]  exp_sz;
        exp_pa = (va >= 32'h8000_0000 && va <= 32'hBFFF_FFFF) ? (va & 32'h1FFF_FFFF) : va;
        if (sz == 2'b00)      exp_wd = 32'(wd[7:0])  * 32'h0101_0101;
        else if (sz == 2'b01) exp_wd = 32'(wd[15:0]) * 32'h0001_0001;
        else                  exp_wd = wd;
        exp_sz = (sz == 2'b11) ? 2'b10 : sz;
        disc = (fl >= 1) && (fl <= 1 + a + d);
        for (int k = 0; k < 60 && !finished; k++) begin
            memenM = 1'b1; memwriteM = wr; memsizeM = sz; aluoutM = va; writedataM = wd;
            flushM = (fl >= 0) && (k >= fl);
            data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = $urandom; ok_now = 0;
            if (bus_done) begin
                data_data_ok = 1'($urandom_range(0, 1));
            end else if (!accepted) begin
                if (data_req) begin
                    if (req_cnt == a) begin
                        data_addr_ok = 1'b1; accepted = 1;
                        if (d == 0) begin data_data_ok = 1'b1; data_rdata = rd; ok_now = 1; end
                    end
                    req_cnt++;
                end
            end else begin
                dcnt++;
                if (dcnt == d) begin data_data_ok = 1'b1; data_rdata = rd; ok_now = 1; end
            end
            @(negedge clk);
            if (k == 0) begin
                check_eq("idle_req", 32'(data_req), 32'd0);
                check_eq("rd_hold", readdataM, last_rd);
            end
            if (stallM) stall_cycles++;
            if (data_req) begin
                req_cycles++;
                check_eq("addr", data_addr, exp_pa);
                check_eq("wdata", data_wdata, exp_wd);
                check_eq("size", 32'(data_size), 32'(exp_sz));
                check_eq("wr", 32'(data_wr), 32'(wr));
                check_eq("addr_nomap", data_addr_nm, va);
            end
            if (ok_now) begin
                bus_done = 1;
                if (disc) finished = 1;
            end else if (k > 0 && !stallM) begin
                finished = 1;
                check_eq("rdata", readdataM, rd);
            end
            @(posedge clk); #1;
        end
        if (!finished) check_eq("timeout", 32'd0, 32'd1);
        check_eq("stall_len", 32'(stall_cycles), 32'(2 + a + d));
        check_eq("req_len", 32'(req_cycles), 32'(a + 1));
        memenM = 1'b0; flushM = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
        if (disc) begin
            @(negedge clk);
            check_eq("disc_rd", readdataM, last_rd);
            check_eq("disc_stall", 32'(stallM), 32'd0);
            check_eq("disc_req", 32'(data_req), 32'd0);
            @(posedge clk); #1;
        end else begin
            last_rd = rd;
        end
    endtask

    // Idle cycles with spurious handshakes. Some cycles also carry an access that a flush suppresses.
    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            memenM = 1'($urandom_range(0, 1)); flushM = memenM; aluoutM = $urandom;
            data_addr_ok = 1'($urandom_range(0, 1)); data_data_ok = 1'($urandom_range(0, 1));
            data_rdata = $urandom;
            @(negedge clk);
            check_eq("idle_stall", 32'(stallM), 32'd0);
            check_eq("idle_rd", readdataM, last_rd);
            @(posedge clk); #1;
            check_eq("idle_req", 32'(data_req), 32'd0);
        end
        memenM = 1'b0; flushM = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
    endtask

    initial begin
        logic [31:0] va;
        int sel;
        rst = 1'b1; memenM = 1'b1; memwriteM = 1'b1; memsizeM = 2'b10; aluoutM = 32'h8000_0040;
        writedataM = 32'h1234_5678; flushM = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
        data_rdata = 32'h0; last_rd = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_stall", 32'(stallM), 32'd0);
        check_eq("rst_req", 32'(data_req), 32'd0);
        check_eq("rst_wr", 32'(data_wr), 32'd0);
        check_eq("rst_size", 32'(data_size), 32'd0);
        check_eq("rst_addr", data_addr, 32'd0);
        check_eq("rst_wdata", data_wdata, 32'd0);
        check_eq("rst_rd", readdataM, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; memenM = 1'b0;
        @(posedge clk); #1;

        // Directed cases
        run_access(1'b0, 2'b10, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 0, 0, -1);
        run_access(1'b1, 2'b00, 32'hA000_0003, 32'h0000_00A5, 32'h1111_2222, 0, 0, -1);
        run_access(1'b1, 2'b01, 32'h8000_0102, 32'h0000_1234, 32'h3333_4444, 0, 1, -1);
        run_access(1'b0, 2'b11, 32'h1000_0000, 32'h0, 32'h5555_6666, 1, 0, -1);
        run_access(1'b0, 2'b10, 32'hBFC0_0020, 32'h0, 32'hCAFE_F00D, 2, 2, -1);
        run_access(1'b0, 2'b10, 32'h8000_0200, 32'h0, 32'h0BAD_0BAD, 0, 3, 3);
        run_access(1'b0, 2'b10, 32'h8000_0204, 32'h0, 32'h7777_8888, 0, 0, -1);
        run_access(1'b0, 2'b10, 32'h8000_0208, 32'h0, 32'h9999_AAAA, 0, 0, -1);
        idle_cycles(4);

        // Reset pulsed while in WAIT
        memenM = 1'b1; memwriteM = 1'b0; memsizeM = 2'b10; aluoutM = 32'h8000_0300;
        @(posedge clk); #1;
        data_addr_ok = 1'b1;
        @(posedge clk); #1;
        data_addr_ok = 1'b0;
        @(negedge clk);
        check_eq("wait_stall", 32'(stallM), 32'd1);
        check_eq("wait_req", 32'(data_req), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_stall", 32'(stallM), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("rst_mid_req", 32'(data_req), 32'd0);
        check_eq("rst_mid_rd", readdataM, 32'd0);
        check_eq("rst_mid_stall2", 32'(stallM), 32'd0);
        rst = 1'b0; memenM = 1'b0; last_rd = 32'h0;
        @(posedge clk); #1;

        // Randomized accesses
        for (int t = 0; t < 60; t++) begin
            sel = $urandom_range(0, 3);
            va  = $urandom;
            if (sel == 0) va = {2'b10, va[29:0]};
            run_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), va, $urandom, $urandom,
                       $urandom_range(0, 3), $urandom_range(0, 3),
                       ($urandom_range(0, 4) == 0) ? $urandom_range(1, 4) : -1);
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_sram_bridge.md
Name: dmem_sram_bridge

Overview:
- Sits directly downstream of the pipelined MIPS core's memory stage, between the core's single-cycle data port (address, write data, write enable, read data) and an SRAM-like split-handshake data bus (req/addr_ok, data_ok).
- Turns each memory-stage access into one bus transaction and stalls the core until the access completes.
- Replicates store data across byte lanes and maps kseg0/kseg1 virtual addresses to physical addresses.
- Allows one outstanding transaction.

Parameters:
- ADDR_MAP_EN, 1, when 1, addresses 0x8000_0000-0xBFFF_FFFF are mapped to {3'b000, addr[28:0]}; when 0, addresses pass through unchanged.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- memenM  in  1  memory-stage access valid (load or store)
- memwriteM  in  1  1 = store, 0 = load
- memsizeM  in  2  00 byte, 01 half, 10 word (11 treated as word)
- aluoutM  in  32  virtual byte address
- writedataM  in  32  store data, right-aligned
- flushM  in  1  memory-stage flush (exception)
- readdataM  out  32  load data, full bus word, unaligned
- stallM  out  1  stall request to the core's hazard unit
- data_req  out  1  bus request
- data_wr  out  1  bus write
- data_size  out  2  bus size (= memsizeM, 11 driven as 10)
- data_addr  out  32  physical address
- data_wdata  out  32  lane-replicated store data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  read data valid / write done
- data_rdata  in  32  read data

Behaviour:
- One clock (clk), synchronous active-high reset (rst).
- Reset state:
  - state = IDLE; data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0; readdataM = 0; discard flag = 0.
  - stallM = 0 while rst is high.
- Store-data lane replication:
  - byte → {4{wd[7:0]}}
  - half → {2{wd[15:0]}}
  - word → wd unchanged
- Alignment is not checked here; the core's exception logic handles misaligned accesses. Size and address are passed through after mapping.
- All bus outputs are registered. They are captured at the IDLE→REQ transition and held stable until addr_ok.
- stallM is combinational:
  - IDLE: memenM & ~flushM
  - REQ, WAIT: 1
  - DONE: 0
- FSM:
  - IDLE: if memenM & ~flushM, capture request and go to REQ. Otherwise stay in IDLE; data_req = 0.
  - REQ: data_req = 1.
    - addr_ok & data_ok in the same cycle → capture data_rdata, go to DONE.
    - addr_ok alone → drop data_req, go to WAIT.
    - No addr_ok → stay in REQ, request held.
  - WAIT: data_req = 0. On data_ok, capture data_rdata into readdataM and go to DONE.
  - DONE: stallM = 0, so the core advances this cycle and readdataM is valid. Next state is IDLE unconditionally; a new request is sampled in the following cycle.
- Latency: with a zero-wait slave, an access seen in cycle 0 is in REQ in cycle 1, DONE in cycle 2, and the core is stalled 2 cycles.
  - Each cycle addr_ok is late adds one stall cycle.
  - Each cycle data_ok is late adds one stall cycle.
- Stores also capture data_rdata; the core ignores it.
- readdataM holds its last value outside DONE.
- data_ok in IDLE or DONE (spurious) is ignored.
- addr_ok outside REQ is ignored.
- Flush:
  - flushM in IDLE suppresses a new request.
  - flushM in REQ or WAIT sets the discard flag. The transaction still runs to data_ok (the request is never withdrawn) and stallM stays 1.
  - On data_ok with discard set: go straight to IDLE, skip DONE, leave readdataM unchanged, clear discard.
- Reset mid-transaction returns the block to IDLE immediately. The bus slave is reset by the same rst.

Test Plan:
- Word load, zero-wait slave, aluoutM = 0x8000_0010, ADDR_MAP_EN = 1 → data_addr = 0x0000_0010, data_wr = 0, data_size = 10. data_rdata = 0xDEAD_BEEF → readdataM = 0xDEAD_BEEF in DONE; stallM high exactly 2 cycles.
- Byte store: writedataM = 0x0000_00A5, aluoutM = 0xA000_0003 → data_wdata = 0xA5A5_A5A5, data_addr = 0x0000_0003, data_size = 00. Half store 0x1234 → data_wdata = 0x1234_1234.
- Slow slave: addr_ok after 3 cycles of REQ, data_ok 2 cycles later → data_req high for 3 cycles with data_addr stable; stallM high for 6 cycles, then low for 1 (DONE).
- flushM asserted in WAIT of a load → stallM stays 1 until data_ok; no DONE cycle; readdataM keeps its previous value; the next access starts normally.
- Back-to-back loads (memenM held, new address after DONE) → second data_req is asserted 2 cycles after DONE (IDLE sample, then REQ). Spurious data_ok in IDLE does not change readdataM.
- rst pulsed while in WAIT → next cycle state = IDLE, data_req = 0, stallM = 0 while rst is high. ADDR_MAP_EN = 0 with aluoutM = 0x8000_0010 → data_addr = 0x8000_0010.
